// File: rtl/lsq_mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ requesters; load responses are
// routed back through an in-order ID FIFO. Define MEMARB_STALL_CNT_EN to add the stall_cnt output.
module lsq_mem_port_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_is_load,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          mem_req_valid,
    output logic                          mem_req_is_load,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr,
    output logic [DATA_WIDTH-1:0]         mem_req_data,
    input  logic                          mem_req_ready,
    input  logic                          mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]         mem_resp_data,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
`ifdef MEMARB_STALL_CNT_EN
    output logic [15:0]                   stall_cnt,
`endif
    output logic                          err_spurious
);

    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FIFO_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_q, rr_d;
    logic                    is_load_q, is_load_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ID_W-1:0]         id_mem_q [MAX_OUTSTANDING];
    logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      eligible;
    logic [ID_W-1:0]         winner;
    logic                    found, accept, push, pop;
    logic [ID_W-1:0]         head_id;

    // Loads are held back once the ID FIFO is full; the registered count is used deliberately.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] &&
                          (!req_is_load[i] || (count_q < CNT_W'(MAX_OUTSTANDING)));
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && eligible[(int'(rr_q) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = ID_W'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    assign accept  = rst_n && found && ((state_q == IDLE) || mem_req_ready);
    assign push    = accept && req_is_load[winner];
    assign pop     = rst_n && mem_resp_valid && (count_q != '0);
    assign head_id = id_mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        is_load_d = is_load_q;
        addr_d    = addr_q;
        data_d    = data_q;
        req_ready = '0;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (mem_req_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            req_ready[winner] = 1'b1;
            rr_d      = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            is_load_d = req_is_load[winner];
            addr_d    = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            data_d    = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ID FIFO bookkeeping; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;
        resp_valid = '0;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == FIFO_AW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            resp_valid[head_id] = 1'b1;
            rd_ptr_d = (rd_ptr_q == FIFO_AW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (mem_resp_valid && (count_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            is_load_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            is_load_q <= is_load_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= winner;
        end
    end

    assign mem_req_valid   = (state_q == BUSY);
    assign mem_req_is_load = is_load_q;
    assign mem_req_addr    = addr_q;
    assign mem_req_data    = data_q;
    assign resp_data       = mem_resp_data;
    assign err_spurious    = err_q;

`ifdef MEMARB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (mem_req_valid && !mem_req_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_lsq_mem_port_arbiter.sv
// Self-checking bench for lsq_mem_port_arbiter: directed vector table, hand sequences for the
// outstanding-limit / routing / spurious cases, and random traffic against a queue-based model.
module tb_lsq_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_is_load, req_ready, resp_valid;
    logic [63:0] req_addr, req_data;
    logic        mem_req_valid, mem_req_is_load, mem_req_ready, mem_resp_valid, err_spurious;
    logic [31:0] mem_req_addr, mem_req_data, mem_resp_data, resp_data;
`ifdef MEMARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    lsq_mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_is_load(req_is_load),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_is_load(mem_req_is_load),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef MEMARB_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .err_spurious(err_spurious)
    );

    typedef struct {
        bit          rstN;
        logic [1:0]  valid;
        logic [1:0]  isLoad;
        logic [31:0] addr0;
        logic [31:0] addr1;
        bit          memReady;
        bit          respValid;
        logic [31:0] respData;
        bit          chkReg;
        logic [1:0]  expReady;
        bit          expMemValid;
        logic [31:0] expAddr;
        logic [1:0]  expResp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit modelOn = 1'b0;

    // Reference model state: the held request, round-robin pointer and a queue of pending load IDs.
    bit          mBusy, mIsLoad, mErr;
    logic [31:0] mAddr, mData;
    int          mRr, mStall;
    int          idQ[$];
    logic [1:0]  eReady, eResp;
    int          eWin;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit r, logic [1:0] v, logic [1:0] l, logic [31:0] a0,
                                logic [31:0] a1, bit mr, bit rv, logic [31:0] rd);
        vec_t t;
        t = '{r, v, l, a0, a1, mr, rv, rd, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00};
        return t;
    endfunction

    function automatic void modelEval();
        eReady = 2'b00;
        eResp  = 2'b00;
        eWin   = -1;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                int i;
                i = (mRr + k) % 2;
                if (eWin < 0 && req_valid[i] && (!req_is_load[i] || idQ.size() < 4)) eWin = i;
            end
            if (eWin >= 0 && (!mBusy || mem_req_ready)) eReady[eWin] = 1'b1;
            if (mem_resp_valid && idQ.size() > 0) eResp[idQ[0]] = 1'b1;
        end
    endfunction

    function automatic void modelUpdate();
        if (!rst_n) begin
            mBusy = 0; mIsLoad = 0; mErr = 0; mAddr = '0; mData = '0; mRr = 0; mStall = 0;
            idQ.delete();
        end else begin
            if (mBusy && !mem_req_ready && mStall < 65535) mStall++;
            if (mem_resp_valid) begin
                if (idQ.size() > 0) void'(idQ.pop_front());
                else mErr = 1;
            end
            if (eReady != 2'b00) begin
                mBusy   = 1;
                mIsLoad = req_is_load[eWin];
                mAddr   = req_addr[eWin*32 +: 32];
                mData   = req_data[eWin*32 +: 32];
                mRr     = (eWin + 1) % 2;
                if (mIsLoad) idQ.push_back(eWin);
            end else if (mBusy && mem_req_ready) begin
                mBusy = 0;
            end
        end
    endfunction

    task automatic modelCheck();
        checkOutput("model_req_ready", req_ready, eReady);
        checkOutput("model_resp_valid", resp_valid, eResp);
        checkOutput("model_resp_data", resp_data, mem_resp_data);
        checkOutput("model_mem_req_valid", mem_req_valid, mBusy);
        checkOutput("model_mem_req_is_load", mem_req_is_load, mIsLoad);
        checkOutput("model_mem_req_addr", mem_req_addr, mAddr);
        checkOutput("model_mem_req_data", mem_req_data, mData);
        checkOutput("model_err_spurious", err_spurious, mErr);
`ifdef MEMARB_STALL_CNT_EN
        checkOutput("model_stall_cnt", stall_cnt, 64'(mStall));
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n          = v.rstN;
        req_valid      = v.valid;
        req_is_load    = v.isLoad;
        req_addr       = {v.addr1, v.addr0};
        req_data       = {v.addr1 + 32'd1, v.addr0 + 32'd1};
        mem_req_ready  = v.memReady;
        mem_resp_valid = v.respValid;
        mem_resp_data  = v.respData;
        #1;
        modelEval();
        if (modelOn) modelCheck();
    endtask

    task automatic advance();
        modelUpdate();
        @(negedge clk);
        modelOn = 1'b1;
    endtask

    vec_t tbl[17];
    vec_t v;
    bit          pValid[2], pLoad[2];
    logic [31:0] pAddr[2];

    initial begin
        // Reset, fairness, backpressure as a cycle-by-cycle table.
        tbl[0]  = '{0, 2'b11, 2'b00, 32'h10, 32'h20, 1, 0, 0, 0, 2'b00, 0, 32'h0,   2'b00};
        tbl[1]  = '{0, 2'b11, 2'b00, 32'h10, 32'h20, 1, 0, 0, 1, 2'b00, 0, 32'h0,   2'b00};
        tbl[2]  = '{1, 2'b11, 2'b00, 32'h10, 32'h20, 1, 0, 0, 1, 2'b01, 0, 32'h0,   2'b00};
        tbl[3]  = '{1, 2'b11, 2'b00, 32'h10, 32'h20, 1, 0, 0, 1, 2'b10, 1, 32'h10,  2'b00};
        tbl[4]  = '{1, 2'b11, 2'b00, 32'h10, 32'h20, 1, 0, 0, 1, 2'b01, 1, 32'h20,  2'b00};
        tbl[5]  = '{1, 2'b11, 2'b00, 32'h10, 32'h20, 1, 0, 0, 1, 2'b10, 1, 32'h10,  2'b00};
        tbl[6]  = '{1, 2'b00, 2'b00, 32'h10, 32'h20, 1, 0, 0, 1, 2'b00, 1, 32'h20,  2'b00};
        tbl[7]  = '{1, 2'b00, 2'b00, 32'h10, 32'h20, 1, 0, 0, 1, 2'b00, 0, 32'h20,  2'b00};
        tbl[8]  = '{1, 2'b01, 2'b01, 32'h100, 32'h20, 0, 0, 0, 1, 2'b01, 0, 32'h20, 2'b00};
        for (int i = 9; i < 14; i++)
            tbl[i] = '{1, 2'b01, 2'b00, 32'h200, 32'h20, 0, 0, 0, 1, 2'b00, 1, 32'h100, 2'b00};
        tbl[14] = '{1, 2'b01, 2'b00, 32'h200, 32'h20, 1, 0, 0, 1, 2'b01, 1, 32'h100, 2'b00};
        tbl[15] = '{1, 2'b00, 2'b00, 32'h200, 32'h20, 1, 0, 0, 1, 2'b00, 1, 32'h200, 2'b00};
        tbl[16] = '{1, 2'b00, 2'b00, 32'h200, 32'h20, 1, 0, 0, 1, 2'b00, 0, 32'h200, 2'b00};

        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d_req_ready", i), req_ready, tbl[i].expReady);
            checkOutput($sformatf("vec%0d_resp_valid", i), resp_valid, tbl[i].expResp);
            if (tbl[i].chkReg) begin
                checkOutput($sformatf("vec%0d_mem_req_valid", i), mem_req_valid, tbl[i].expMemValid);
                checkOutput($sformatf("vec%0d_mem_req_addr", i), mem_req_addr, tbl[i].expAddr);
                checkOutput($sformatf("vec%0d_err", i), err_spurious, 1'b0);
            end
            advance();
        end
`ifdef MEMARB_STALL_CNT_EN
        checkOutput("stall_cnt_after_backpressure", stall_cnt, 16'd5);
`endif

        // Drain the load left from the backpressure case.
        applyStimulus(mk(1, 2'b00, 2'b00, 0, 0, 1, 1, 32'hAAAA));
        checkOutput("drain_resp_valid", resp_valid, 2'b01);
        advance();

        // Outstanding limit: four loads from requester 1 fill the ID FIFO.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk(1, 2'b10, 2'b10, 0, 32'h400 + i, 1, 0, 0));
            checkOutput($sformatf("s4_load%0d_ready", i), req_ready, 2'b10);
            advance();
        end
        applyStimulus(mk(1, 2'b11, 2'b10, 32'h300, 32'h500, 1, 0, 0));
        checkOutput("s4_store_granted_when_full", req_ready, 2'b01);
        advance();
        applyStimulus(mk(1, 2'b10, 2'b10, 0, 32'h500, 1, 1, 32'hDEAD));
        checkOutput("s4_load_blocked_during_pop", req_ready, 2'b00);
        checkOutput("s4_resp_valid", resp_valid, 2'b10);
        checkOutput("s4_resp_data", resp_data, 32'hDEAD);
        advance();
        applyStimulus(mk(1, 2'b10, 2'b10, 0, 32'h500, 1, 0, 0));
        checkOutput("s4_load_granted_after_pop", req_ready, 2'b10);
        advance();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk(1, 2'b00, 2'b00, 0, 0, 1, 1, 32'hBEE0 + i));
            checkOutput($sformatf("s4_drain%0d_resp", i), resp_valid, 2'b10);
            advance();
        end

        // Routing: loads from 0, 1, 0 and three in-order responses.
        applyStimulus(mk(1, 2'b01, 2'b01, 32'hA0, 0, 1, 0, 0));
        checkOutput("s5_issue0", req_ready, 2'b01);
        advance();
        applyStimulus(mk(1, 2'b10, 2'b10, 0, 32'hA1, 1, 0, 0));
        checkOutput("s5_issue1", req_ready, 2'b10);
        advance();
        applyStimulus(mk(1, 2'b01, 2'b01, 32'hA2, 0, 1, 0, 0));
        checkOutput("s5_issue2", req_ready, 2'b01);
        advance();
        applyStimulus(mk(1, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(1, 2'b00, 2'b00, 0, 0, 1, 1, 32'hD0 + i));
            checkOutput($sformatf("s5_resp%0d_valid", i), resp_valid, (i == 1) ? 2'b10 : 2'b01);
            checkOutput($sformatf("s5_resp%0d_data", i), resp_data, 32'hD0 + i);
            advance();
        end

        // Spurious response with an empty FIFO.
        applyStimulus(mk(1, 2'b00, 2'b00, 0, 0, 1, 1, 32'h5555));
        checkOutput("s6_no_resp_valid", resp_valid, 2'b00);
        checkOutput("s6_err_before", err_spurious, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(1, 2'b00, 2'b00, 0, 0, 1, 0, 0));
            advance();
        end
        checkOutput("s6_err_sticky", err_spurious, 1'b1);
        applyStimulus(mk(0, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        advance();
        checkOutput("s6_err_cleared_by_reset", err_spurious, 1'b0);

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 2; i++) begin
            pValid[i] = 0; pLoad[i] = 0; pAddr[i] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            bit rv;
            for (int i = 0; i < 2; i++) begin
                if (!pValid[i] && $urandom_range(1, 0) == 1) begin
                    pValid[i] = 1;
                    pLoad[i]  = ($urandom_range(1, 0) == 1);
                    pAddr[i]  = $urandom;
                end
            end
            rv = (idQ.size() > 0) ? ($urandom_range(2, 0) == 0) : ($urandom_range(63, 0) == 0);
            v = mk((c != 1500), {pValid[1], pValid[0]}, {pLoad[1], pLoad[0]}, pAddr[0], pAddr[1],
                   ($urandom_range(3, 0) != 0), rv, $urandom);
            applyStimulus(v);
            for (int i = 0; i < 2; i++) if (eReady[i]) pValid[i] = 0;
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
